i2c_slave_regfile: RTL and testbench

Parametrised I2C target with an internal byte-wide register file, supporting multi-byte writes and reads with an auto-incrementing register pointer, repeated START, and STOP detection in any state. It sits on the board-level I2C bus. It exposes the register file to on-chip logic through a parallel read port and a one-cycle write-notification strobe. SDA is driven open-drain: the block only ever pulls it low or releases it.

---
 rtl/i2c_slave_regfile.sv | 239 +++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-wide register file and auto-incrementing pointer.
// SDA is open-drain: the block only ever pulls the line low or releases it.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55,
  parameter int         NUM_REGS   = 16,
  parameter int         PTR_W      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             SCL,
  inout  wire              SDA,
  input  logic [PTR_W-1:0] reg_sel,
  output logic [7:0]       reg_q,
  output logic             wr_stb,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_A_ACK     = 4'd2,
    S_PTR       = 4'd3,
    S_P_ACK     = 4'd4,
    S_WDATA     = 4'd5,
    S_W_ACK     = 4'd6,
    S_RDATA     = 4'd7,
    S_R_ACK     = 4'd8,
    S_WAIT_STOP = 4'd9
  } state_t;

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic             scl_meta_q, scl_s_q, scl_prev_q;
  logic             sda_meta_q, sda_s_q, sda_prev_q;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [6:0]       sh_q, sh_d;
  logic [6:0]       tx_q, tx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             wr_stb_q, wr_stb_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic [7:0]       regs_q [NUM_REGS];

  logic             scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]       byte_in;

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_q    = regs_q[reg_sel];
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

  // Bus conditions seen through the synchronised copies; START/STOP need SCL stable high.
  assign scl_rise  = scl_s_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s_q & scl_prev_q;
  assign start_det = scl_s_q & scl_prev_q & sda_prev_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_prev_q & ~sda_prev_q & sda_s_q;
  assign byte_in   = {sh_q, sda_s_q};

  // Two-flop synchronisers plus previous-cycle copies, idling at the released bus level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta_q <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_s_q    <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= SCL;
      scl_s_q    <= scl_meta_q;
      scl_prev_q <= scl_s_q;
      sda_meta_q <= SDA;
      sda_s_q    <= sda_meta_q;
      sda_prev_q <= sda_s_q;
    end
  end

  // Protocol next-state and datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      cnt_d    = 4'd0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = 4'd0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_in[6:0];
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == S_ADDR) begin
                state_d = (byte_in[7:1] == SLAVE_ADDR) ? S_A_ACK : S_WAIT_STOP;
              end else if (state_q == S_PTR) begin
                if ({1'b0, byte_in} < NUM_REGS_W) begin
                  ptr_d   = byte_in[PTR_W-1:0];
                  state_d = S_P_ACK;
                end else begin
                  state_d = S_WAIT_STOP;
                end
              end else begin
                wr_stb_d  = 1'b1;
                wr_addr_d = ptr_q;
                wr_data_d = byte_in;
                ptr_d     = ptr_q + PTR_W'(1);
                state_d   = S_W_ACK;
              end
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end
        // First fall starts the ACK drive, the second ends it; sh_q[0] is still R/W here.
        S_A_ACK, S_P_ACK, S_W_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              if ((state_q == S_A_ACK) && sh_q[0]) begin
                tx_d     = regs_q[ptr_q][6:0];
                sda_oe_d = ~regs_q[ptr_q][7];
                state_d  = S_RDATA;
              end else begin
                state_d = (state_q == S_A_ACK) ? S_PTR : S_WDATA;
              end
            end
          end else begin
            state_d = state_q;
          end
        end
        S_RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = 4'd0;
              state_d  = S_R_ACK;
            end else begin
              tx_d     = {tx_q[5:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end else begin
            state_d = state_q;
          end
        end
        // cnt_q==1 marks an ACK seen on the rising edge; the next byte starts at the fall.
        S_R_ACK: begin
          if (scl_rise) begin
            if (sda_s_q) begin
              state_d = S_WAIT_STOP;
            end else begin
              ptr_d = ptr_q + PTR_W'(1);
              cnt_d = 4'd1;
            end
          end else if (scl_fall && (cnt_q == 4'd1)) begin
            cnt_d    = 4'd0;
            tx_d     = regs_q[ptr_q][6:0];
            sda_oe_d = ~regs_q[ptr_q][7];
            state_d  = S_RDATA;
          end else begin
            state_d = state_q;
          end
        end
        S_IDLE, S_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d inside {S_A_ACK, S_PTR, S_P_ACK, S_WDATA, S_W_ACK, S_RDATA, S_R_ACK});
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      sh_q      <= 7'd0;
      tx_q      <= 7'd0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  // Register file, written by the same edge that raises wr_stb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (wr_stb_d) begin
      regs_q[wr_addr_d] <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: a bus master drives SCL/SDA with fixed timing and compares
// ACKs, read data, write strobes and the parallel port against hand values.
module tb_i2c_slave_regfile;

  localparam time Q = 100;

  logic       clk;
  logic       reset;
  logic       scl;
  logic       m_oe;
  wire        sda_w;
  logic [3:0] reg_sel;
  logic [7:0] reg_q;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int         n_checks;
  int         n_fail;
  int         stb_cnt;
  logic [3:0] cap_addr [8];
  logic [7:0] cap_data [8];
  logic       ack;
  logic [7:0] rd;

  assign sda_w = m_oe ? 1'b0 : 1'bz;
  pullup (sda_w);

  i2c_slave_regfile dut (
    .clk     (clk),
    .reset   (reset),
    .SCL     (scl),
    .SDA     (sda_w),
    .reg_sel (reg_sel),
    .reg_q   (reg_q),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe cycle with the write it reports.
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      if (stb_cnt < 8) begin
        cap_addr[stb_cnt] = wr_addr;
        cap_data[stb_cnt] = wr_data;
      end
      stb_cnt = stb_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic i2c_start();
    m_oe = 1'b0; #Q;
    scl  = 1'b1; #Q;
    m_oe = 1'b1; #Q;
    scl  = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1; #Q;
    scl  = 1'b1; #Q;
    m_oe = 1'b0; #Q;
  endtask

  task automatic write_bit(input logic b);
    m_oe = ~b; #Q;
    scl  = 1'b1; #(2*Q);
    scl  = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    m_oe = 1'b0; #Q;
    scl  = 1'b1; #Q;
    b    = sda_w; #Q;
    scl  = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(ack_bit);
  endtask

  task automatic peek(input logic [3:0] sel, output logic [7:0] v);
    reg_sel = sel;
    #10;
    v = reg_q;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    stb_cnt  = 0;
    reset    = 1'b1;
    scl      = 1'b1;
    m_oe     = 1'b0;
    reg_sel  = 4'd0;
    #23;
    reset = 1'b0;
    @(negedge clk);
    #20;

    // Reset state
    check_eq("rst_sda", sda_w, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_stb", wr_stb, 1'b0);
    check_eq("rst_waddr", wr_addr, 4'd0);
    check_eq("rst_wdata", wr_data, 8'h00);
    check_eq("rst_regq", reg_q, 8'h00);

    // Basic write of two bytes at pointer 3
    i2c_start();
    write_byte(8'hAA, ack); check_eq("t1_addr_ack", ack, 1'b0);
    write_byte(8'h03, ack); check_eq("t1_ptr_ack", ack, 1'b0);
    check_eq("t1_busy", busy, 1'b1);
    write_byte(8'h11, ack); check_eq("t1_d0_ack", ack, 1'b0);
    write_byte(8'h22, ack); check_eq("t1_d1_ack", ack, 1'b0);
    i2c_stop();
    check_eq("t1_busy_stop", busy, 1'b0);
    check_eq("t1_stb_cnt", stb_cnt, 2);
    check_eq("t1_cap0_addr", cap_addr[0], 4'd3);
    check_eq("t1_cap0_data", cap_data[0], 8'h11);
    check_eq("t1_cap1_addr", cap_addr[1], 4'd4);
    check_eq("t1_cap1_data", cap_data[1], 8'h22);
    peek(4'd3, rd); check_eq("t1_reg3", rd, 8'h11);
    peek(4'd4, rd); check_eq("t1_reg4", rd, 8'h22);

    // Foreign address is not acknowledged and writes nothing
    i2c_start();
    write_byte(8'hA8, ack); check_eq("t2_addr_nack", ack, 1'b1);
    check_eq("t2_busy", busy, 1'b0);
    write_byte(8'h03, ack); check_eq("t2_byte_nack", ack, 1'b1);
    i2c_stop();
    check_eq("t2_stb_cnt", stb_cnt, 2);
    i2c_start();
    write_byte(8'hAA, ack); check_eq("t2_readdr_ack", ack, 1'b0);
    i2c_stop();

    // Pointer wrap and out-of-range pointer
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h0F, ack); check_eq("t3_ptr_ack", ack, 1'b0);
    write_byte(8'hA1, ack);
    write_byte(8'hB2, ack); check_eq("t3_d1_ack", ack, 1'b0);
    i2c_stop();
    check_eq("t3_stb_cnt", stb_cnt, 4);
    check_eq("t3_cap3_addr", cap_addr[3], 4'd0);
    peek(4'd15, rd); check_eq("t3_reg15", rd, 8'hA1);
    peek(4'd0, rd);  check_eq("t3_reg0", rd, 8'hB2);
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h10, ack); check_eq("t3_ptr16_nack", ack, 1'b1);
    i2c_stop();
    // Pointer must still be 1 (reg1 = 0), not 0 (reg0 = 0xB2)
    i2c_start();
    write_byte(8'hAB, ack); check_eq("t3_rd_ack", ack, 1'b0);
    read_byte(1'b1, rd);    check_eq("t3_rd_ptr1", rd, 8'h00);
    i2c_stop();

    // Multi-byte read after a pointer write and repeated START
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h05, ack);
    write_byte(8'h5A, ack);
    write_byte(8'hC3, ack);
    write_byte(8'h0F, ack);
    i2c_stop();
    check_eq("t4_stb_cnt", stb_cnt, 7);
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h05, ack); check_eq("t4_ptr_ack", ack, 1'b0);
    i2c_start();
    write_byte(8'hAB, ack); check_eq("t4_raddr_ack", ack, 1'b0);
    read_byte(1'b0, rd); check_eq("t4_rd0", rd, 8'h5A);
    read_byte(1'b0, rd); check_eq("t4_rd1", rd, 8'hC3);
    read_byte(1'b1, rd); check_eq("t4_rd2", rd, 8'h0F);
    check_eq("t4_sda_rel", sda_w, 1'b1);
    check_eq("t4_busy_nack", busy, 1'b0);
    i2c_stop();

    // Byte aborted by STOP after 4 bits is discarded
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h02, ack); check_eq("t5_ptr_ack", ack, 1'b0);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b1);
    write_bit(1'b1);
    i2c_stop();
    check_eq("t5_stb_cnt", stb_cnt, 7);
    peek(4'd2, rd); check_eq("t5_reg2", rd, 8'h00);
    check_eq("t5_busy", busy, 1'b0);

    // Reset while the slave pulls SDA low for the first read bit (0x5A MSB = 0)
    i2c_start();
    write_byte(8'hAA, ack);
    write_byte(8'h05, ack);
    i2c_start();
    write_byte(8'hAB, ack);
    check_eq("t6_sda_driven", sda_w, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("t6_sda_rel", sda_w, 1'b1);
    #9;
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_stb", wr_stb, 1'b0);
    check_eq("t6_waddr", wr_addr, 4'd0);
    check_eq("t6_wdata", wr_data, 8'h00);
    peek(4'd5, rd);  check_eq("t6_reg5", rd, 8'h00);
    peek(4'd15, rd); check_eq("t6_reg15", rd, 8'h00);
    reset = 1'b0;
    scl   = 1'b1;
    #Q;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
